// File: rtl/lock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lock_pkg: shared state encoding, default tick counts and counter sizing    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lock_pkg;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_ALARM   = 2'd3
  } lock_sup_state_e;

  localparam int DEF_OPEN_TICKS    = 5;
  localparam int DEF_LOCKOUT_TICKS = 10;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lock_timer: loadable tick-driven down-counter, saturating at zero; done    |
// | fires in the cycle whose tick takes the count from 1 to 0.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lock_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          done
);

  localparam logic [TW-1:0] c_zero = '0;
  localparam logic [TW-1:0] c_one  = TW'(1);

  logic [TW-1:0] count_d, count_q;

  // A load always beats a coincident tick.
  always_comb begin
    count_d = count_q;
    done    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != c_zero)) begin
      count_d = count_q - c_one;
      done    = (count_q == c_one);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= c_zero;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lock_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lock_supervisor: sequences the keypad lock FSM -- attempt counting, timed  |
// | lockouts, alarm escalation and door-open window.                           |
// | Optional buzzer logic: define LOCK_SUPERVISOR_BEEP_EN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int MAX_ATTEMPTS  = 3,
  parameter int MAX_LOCKOUTS  = 2,
  parameter int OPEN_TICKS    = DEF_OPEN_TICKS,
  parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
  parameter int TW            = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                tick,
  input  logic                                key_en,
  input  logic                                anykey,
  input  logic                                unlock,
  input  logic                                fail,
  output logic                                fsm_en,
  output logic                                fsm_clr,
  output logic                                door_open,
  output logic                                lockout,
  output logic                                alarm,
  output logic [cnt_width(MAX_ATTEMPTS)-1:0]  attempts_left,
  output logic                                beep
);

  localparam int AW = cnt_width(MAX_ATTEMPTS);
  localparam int LW = cnt_width(MAX_LOCKOUTS);

  localparam logic [AW-1:0] c_att_max   = AW'(MAX_ATTEMPTS);
  localparam logic [AW-1:0] c_att_one   = AW'(1);
  localparam logic [LW-1:0] c_lock_max  = LW'(MAX_LOCKOUTS);
  localparam logic [LW-1:0] c_lock_one  = LW'(1);
  localparam logic [TW-1:0] c_open_ld   = TW'(OPEN_TICKS);
  localparam logic [TW-1:0] c_lock_ld   = TW'(LOCKOUT_TICKS);

  lock_sup_state_e state_d, state_q;
  logic [AW-1:0]   attempts_d, attempts_q;
  logic [LW-1:0]   lock_cnt_d, lock_cnt_q;
  logic            fsm_clr_d, fsm_clr_q;
  logic            door_open_d, door_open_q;
  logic            lockout_d, lockout_q;
  logic            alarm_d, alarm_q;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_done;

  lock_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .done     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    attempts_d = attempts_q;
    lock_cnt_d = lock_cnt_q;
    fsm_clr_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = c_open_ld;
    case (state_q)
      ST_ARMED: begin
        if (key_en && unlock) begin
          state_d    = ST_OPEN;
          tmr_load   = 1'b1;
          tmr_val    = c_open_ld;
          attempts_d = c_att_max;
          lock_cnt_d = '0;
        end else if (key_en && fail) begin
          if (attempts_q > c_att_one) begin
            attempts_d = attempts_q - c_att_one;
            fsm_clr_d  = 1'b1;
          end else begin
            attempts_d = '0;
            // Escalate once the allowed number of lockouts has been used up.
            if ((lock_cnt_q + c_lock_one) == c_lock_max) begin
              state_d = ST_ALARM;
            end else begin
              state_d    = ST_LOCKOUT;
              tmr_load   = 1'b1;
              tmr_val    = c_lock_ld;
              lock_cnt_d = lock_cnt_q + c_lock_one;
            end
          end
        end
      end
      ST_OPEN: begin
        if (anykey) begin
          tmr_load = 1'b1;
          tmr_val  = c_open_ld;
        end else if (tmr_done) begin
          state_d   = ST_ARMED;
          fsm_clr_d = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d    = ST_ARMED;
          attempts_d = c_att_max;
          fsm_clr_d  = 1'b1;
        end
      end
      ST_ALARM: begin
        state_d = ST_ALARM;
      end
      default: begin
        state_d = ST_ARMED;
      end
    endcase
    door_open_d = (state_d == ST_OPEN);
    lockout_d   = (state_d == ST_LOCKOUT) || (state_d == ST_ALARM);
    alarm_d     = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ARMED;
      attempts_q  <= c_att_max;
      lock_cnt_q  <= '0;
      fsm_clr_q   <= 1'b0;
      door_open_q <= 1'b0;
      lockout_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      attempts_q  <= attempts_d;
      lock_cnt_q  <= lock_cnt_d;
      fsm_clr_q   <= fsm_clr_d;
      door_open_q <= door_open_d;
      lockout_q   <= lockout_d;
      alarm_q     <= alarm_d;
    end
  end

  assign fsm_en        = key_en && (state_q == ST_ARMED);
  assign fsm_clr       = fsm_clr_q;
  assign door_open     = door_open_q;
  assign lockout       = lockout_q;
  assign alarm         = alarm_q;
  assign attempts_left = attempts_q;

`ifdef LOCK_SUPERVISOR_BEEP_EN
  logic beep_d, beep_q;

  // Lockout entry forces the buzzer on until the first tick inside the lockout.
  always_comb begin
    beep_d = 1'b0;
    case (state_q)
      ST_ARMED:   beep_d = key_en & anykey;
      ST_LOCKOUT: beep_d = beep_q & ~tick;
      ST_ALARM:   beep_d = beep_q ^ tick;
      default:    beep_d = 1'b0;
    endcase
    if ((state_q != ST_LOCKOUT) && (state_d == ST_LOCKOUT)) begin
      beep_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beep_q <= 1'b0;
    end else begin
      beep_q <= beep_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lock_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lock_supervisor: directed self-checking bench for lock_supervisor       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lock_supervisor;

`ifdef LOCK_SUPERVISOR_BEEP_EN
  localparam logic BEEP_ON = 1'b1;
`else
  localparam logic BEEP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick = 1'b0;
  logic       key_en = 1'b0;
  logic       anykey = 1'b0;
  logic       unlock = 1'b0;
  logic       fail = 1'b0;
  logic       fsm_en, fsm_clr, door_open, lockout, alarm, beep;
  logic [1:0] attempts_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lock_supervisor dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .key_en        (key_en),
    .anykey        (anykey),
    .unlock        (unlock),
    .fail          (fail),
    .fsm_en        (fsm_en),
    .fsm_clr       (fsm_clr),
    .door_open     (door_open),
    .lockout       (lockout),
    .alarm         (alarm),
    .attempts_left (attempts_left),
    .beep          (beep)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic u, input logic f, input logic a);
    key_en = 1'b1; unlock = u; fail = f; anykey = a;
    cyc(1);
    key_en = 1'b0; unlock = 1'b0; fail = 1'b0; anykey = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_door", door_open, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_attempts", attempts_left, 3);
    chk("rst_clr", fsm_clr, 0);
    chk("rst_fsm_en", fsm_en, 0);
    chk("rst_beep", beep, 0);
    #9 reset_n = 1'b1;
    cyc(1);

    // Correct code opens the door for five ticks
    key_en = 1'b1; unlock = 1'b1; #1;
    chk("fsm_en_armed", fsm_en, 1);
    cyc(1);
    chk("open_door", door_open, 1);
    chk("fsm_en_open", fsm_en, 0);
    key_en = 1'b0; unlock = 1'b0;
    ticks(4);
    chk("open_tick4_door", door_open, 1);
    chk("open_tick4_clr", fsm_clr, 0);
    ticks(1);
    chk("open_close_door", door_open, 0);
    chk("open_close_clr", fsm_clr, 1);
    cyc(1);
    chk("open_clr_once", fsm_clr, 0);

    // Three wrong codes -> first lockout
    key(0, 1, 0);
    chk("fail1_att", attempts_left, 2);
    chk("fail1_clr", fsm_clr, 1);
    key(0, 1, 0);
    chk("fail2_att", attempts_left, 1);
    key(0, 1, 0);
    chk("fail3_att", attempts_left, 0);
    chk("fail3_lockout", lockout, 1);
    chk("fail3_beep", beep, BEEP_ON);
    key_en = 1'b1; #1;
    chk("lockout_fsm_en", fsm_en, 0);
    key_en = 1'b0;
    ticks(9);
    chk("lockout_tick9", lockout, 1);
    ticks(1);
    chk("lockout_end", lockout, 0);
    chk("lockout_end_att", attempts_left, 3);
    chk("lockout_end_clr", fsm_clr, 1);

    // Second round of failures escalates to alarm on the sixth fail
    key(0, 1, 0);
    key(0, 1, 0);
    chk("fail5_att", attempts_left, 1);
    key(0, 1, 0);
    chk("fail6_alarm", alarm, 1);
    chk("fail6_lockout", lockout, 1);
    chk("fail6_att", attempts_left, 0);
    ticks(1);
    chk("alarm_beep_toggle", beep, BEEP_ON);
    ticks(11);
    key(1, 0, 1);
    chk("alarm_held", alarm, 1);
    chk("alarm_no_open", door_open, 0);
    key_en = 1'b1; #1;
    chk("alarm_fsm_en", fsm_en, 0);
    key_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("alarm_reset", alarm, 0);
    chk("alarm_reset_lockout", lockout, 0);
    chk("alarm_reset_att", attempts_left, 3);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);

    // Hold-open: anykey coincident with tick 4 reloads the window
    key(1, 0, 0);
    chk("hold_open", door_open, 1);
    ticks(3);
    tick = 1'b1; anykey = 1'b1;
    cyc(1);
    tick = 1'b0; anykey = 1'b0;
    ticks(4);
    chk("hold_after4", door_open, 1);
    ticks(1);
    chk("hold_close", door_open, 0);
    chk("hold_close_clr", fsm_clr, 1);

    // fail without key_en is ignored; unlock beats fail
    fail = 1'b1;
    cyc(2);
    fail = 1'b0;
    chk("nokey_att", attempts_left, 3);
    chk("nokey_clr", fsm_clr, 0);
    key(0, 1, 1);
    chk("keybeep_att", attempts_left, 2);
    chk("keybeep_beep", beep, BEEP_ON);
    key(1, 1, 0);
    chk("both_open", door_open, 1);
    chk("both_att", attempts_left, 3);

    // Asynchronous reset mid-window
    ticks(2);
    #1 reset_n = 1'b0;
    #1;
    chk("async_door", door_open, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
    chk("post_reset_door", door_open, 0);
    chk("post_reset_att", attempts_left, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
